// File: rtl/reorder_buffer_2w.sv
// reorder_buffer_2w: 2-wide in-order reorder buffer between rename and retirement.
module reorder_buffer_2w #(
  parameter int DEPTH = 16,
  parameter int TAG_W = 4
) (
  input  logic             Clk,
  input  logic             Rst_n,
  input  logic             Flush,
  input  logic             Alloc1_en,
  input  logic             Alloc1_RegW,
  input  logic [4:0]       Alloc1_Rdst,
  input  logic [5:0]       Alloc1_Phydst,
  input  logic             Alloc2_en,
  input  logic             Alloc2_RegW,
  input  logic [4:0]       Alloc2_Rdst,
  input  logic [5:0]       Alloc2_Phydst,
  output logic [TAG_W-1:0] Alloc_Tag1,
  output logic [TAG_W-1:0] Alloc_Tag2,
  output logic             ROB_Stall,
  input  logic             WB1_en,
  input  logic [TAG_W-1:0] WB1_Tag,
  input  logic             WB2_en,
  input  logic [TAG_W-1:0] WB2_Tag,
  output logic             Commit1_Commit,
  output logic [4:0]       Commit1_Rdst,
  output logic [5:0]       Commit1_Phydst,
  output logic             Commit2_Commit,
  output logic [4:0]       Commit2_Rdst,
  output logic [5:0]       Commit2_Phydst,
  output logic [TAG_W:0]   Count
);
  logic [TAG_W-1:0] head, tail, head1;
  logic [DEPTH-1:0] valid, done;
  logic [4:0]       rdst_q [DEPTH];
  logic [5:0]       phy_q  [DEPTH];
  logic [1:0]       req, ret;
  logic             keep1, keep2;
  always_comb begin
    req            = {1'b0, Alloc1_en} + {1'b0, Alloc2_en};
    ROB_Stall      = ((TAG_W+1)'(req) > (TAG_W+1)'(DEPTH) - Count) | Flush;
    Alloc_Tag1     = tail;
    Alloc_Tag2     = tail + TAG_W'(Alloc1_en);
    head1          = head + TAG_W'(1);
    Commit1_Commit = valid[head] & done[head] & !Flush;
    Commit2_Commit = Commit1_Commit & valid[head1] & done[head1];
    ret            = {1'b0, Commit1_Commit} + {1'b0, Commit2_Commit};
    Commit1_Rdst   = Commit1_Commit ? rdst_q[head]  : '0;
    Commit1_Phydst = Commit1_Commit ? phy_q[head]   : '0;
    Commit2_Rdst   = Commit2_Commit ? rdst_q[head1] : '0;
    Commit2_Phydst = Commit2_Commit ? phy_q[head1]  : '0;
    keep1          = Alloc1_RegW & (|Alloc1_Rdst);
    keep2          = Alloc2_RegW & (|Alloc2_Rdst);
  end
  // later assignments win: retire clears, allocation overrides a same-cycle writeback
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      head  <= '0;
      tail  <= '0;
      Count <= '0;
      valid <= '0;
      done  <= '0;
    end else if (Flush) begin
      valid <= '0;
      done  <= '0;
      tail  <= head;
      Count <= '0;
    end else begin
      for (int i = 0; i < DEPTH; i++)
        if (valid[i] && ((WB1_en && WB1_Tag == TAG_W'(i)) || (WB2_en && WB2_Tag == TAG_W'(i))))
          done[i] <= 1'b1;
      if (Commit1_Commit) begin
        valid[head] <= 1'b0;
        done[head]  <= 1'b0;
      end
      if (Commit2_Commit) begin
        valid[head1] <= 1'b0;
        done[head1]  <= 1'b0;
      end
      if (!ROB_Stall && Alloc1_en) begin
        valid[Alloc_Tag1] <= 1'b1;
        done[Alloc_Tag1]  <= 1'b0;
      end
      if (!ROB_Stall && Alloc2_en) begin
        valid[Alloc_Tag2] <= 1'b1;
        done[Alloc_Tag2]  <= 1'b0;
      end
      head  <= head + TAG_W'(ret);
      tail  <= ROB_Stall ? tail : tail + TAG_W'(req);
      Count <= Count + (ROB_Stall ? '0 : (TAG_W+1)'(req)) - (TAG_W+1)'(ret);
    end
  end
  always_ff @(posedge Clk) begin
    if (!ROB_Stall && Alloc1_en) begin
      rdst_q[Alloc_Tag1] <= keep1 ? Alloc1_Rdst : '0;
      phy_q[Alloc_Tag1]  <= keep1 ? Alloc1_Phydst : '0;
    end
    if (!ROB_Stall && Alloc2_en) begin
      rdst_q[Alloc_Tag2] <= keep2 ? Alloc2_Rdst : '0;
      phy_q[Alloc_Tag2]  <= keep2 ? Alloc2_Phydst : '0;
    end
  end
endmodule

// File: tb/tb_reorder_buffer_2w.sv
// tb_reorder_buffer_2w: directed plus random checks of reorder_buffer_2w against a queue model.
module tb_reorder_buffer_2w;
  localparam int DEPTH = 16;
  localparam int TAG_W = 4;
  logic             Clk = 0, Rst_n = 0, Flush = 0;
  logic             Alloc1_en = 0, Alloc1_RegW = 0, Alloc2_en = 0, Alloc2_RegW = 0;
  logic [4:0]       Alloc1_Rdst = 0, Alloc2_Rdst = 0;
  logic [5:0]       Alloc1_Phydst = 0, Alloc2_Phydst = 0;
  logic             WB1_en = 0, WB2_en = 0;
  logic [TAG_W-1:0] WB1_Tag = 0, WB2_Tag = 0;
  logic [TAG_W-1:0] Alloc_Tag1, Alloc_Tag2;
  logic             ROB_Stall, Commit1_Commit, Commit2_Commit;
  logic [4:0]       Commit1_Rdst, Commit2_Rdst;
  logic [5:0]       Commit1_Phydst, Commit2_Phydst;
  logic [TAG_W:0]   Count;

  reorder_buffer_2w #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .Flush(Flush),
    .Alloc1_en(Alloc1_en), .Alloc1_RegW(Alloc1_RegW), .Alloc1_Rdst(Alloc1_Rdst), .Alloc1_Phydst(Alloc1_Phydst),
    .Alloc2_en(Alloc2_en), .Alloc2_RegW(Alloc2_RegW), .Alloc2_Rdst(Alloc2_Rdst), .Alloc2_Phydst(Alloc2_Phydst),
    .Alloc_Tag1(Alloc_Tag1), .Alloc_Tag2(Alloc_Tag2), .ROB_Stall(ROB_Stall),
    .WB1_en(WB1_en), .WB1_Tag(WB1_Tag), .WB2_en(WB2_en), .WB2_Tag(WB2_Tag),
    .Commit1_Commit(Commit1_Commit), .Commit1_Rdst(Commit1_Rdst), .Commit1_Phydst(Commit1_Phydst),
    .Commit2_Commit(Commit2_Commit), .Commit2_Rdst(Commit2_Rdst), .Commit2_Phydst(Commit2_Phydst),
    .Count(Count)
  );

  always #5 Clk = ~Clk;

  typedef struct {int tag; int rdst; int phy; bit done;} ent_t;
  ent_t q[$];
  int   mtail = 0;
  int   n_tests = 0, n_fail = 0;

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  function automatic int kept(bit regw, int rd, int v);
    return (regw && rd != 0) ? v : 0;
  endfunction

  task automatic idle();
    Flush = 0; Alloc1_en = 0; Alloc2_en = 0; WB1_en = 0; WB2_en = 0;
  endtask

  task automatic drive(bit a1, bit w1, int r1, int p1, bit a2, bit w2, int r2, int p2);
    Alloc1_en = a1; Alloc1_RegW = w1; Alloc1_Rdst = 5'(r1); Alloc1_Phydst = 6'(p1);
    Alloc2_en = a2; Alloc2_RegW = w2; Alloc2_Rdst = 5'(r2); Alloc2_Phydst = 6'(p2);
  endtask

  task automatic wb(bit e1, int t1, bit e2, int t2);
    WB1_en = e1; WB1_Tag = TAG_W'(t1); WB2_en = e2; WB2_Tag = TAG_W'(t2);
  endtask

  // called at a falling edge with inputs already applied; leaves at the next falling edge
  task automatic step();
    int cnt, req;
    bit st, c1, c2;
    #1;
    cnt = q.size();
    req = int'(Alloc1_en) + int'(Alloc2_en);
    st  = (req > DEPTH - cnt) || Flush;
    c1  = !Flush && cnt > 0 && q[0].done;
    c2  = c1 && cnt > 1 && q[1].done;
    chk("count", Count, cnt);
    chk("stall", ROB_Stall, st);
    chk("tag1", Alloc_Tag1, mtail);
    chk("tag2", Alloc_Tag2, (mtail + int'(Alloc1_en)) % DEPTH);
    chk("c1", Commit1_Commit, c1);
    chk("c1_rdst", Commit1_Rdst, c1 ? q[0].rdst : 0);
    chk("c1_phy", Commit1_Phydst, c1 ? q[0].phy : 0);
    chk("c2", Commit2_Commit, c2);
    chk("c2_rdst", Commit2_Rdst, c2 ? q[1].rdst : 0);
    chk("c2_phy", Commit2_Phydst, c2 ? q[1].phy : 0);
    @(posedge Clk);
    if (Flush) begin
      mtail = (mtail - q.size() + DEPTH) % DEPTH;
      q.delete();
    end else begin
      foreach (q[i])
        if ((WB1_en && q[i].tag == int'(WB1_Tag)) || (WB2_en && q[i].tag == int'(WB2_Tag)))
          q[i].done = 1;
      if (c1) void'(q.pop_front());
      if (c2) void'(q.pop_front());
      if (!st && Alloc1_en) begin
        q.push_back('{mtail, kept(Alloc1_RegW, Alloc1_Rdst, Alloc1_Rdst), kept(Alloc1_RegW, Alloc1_Rdst, Alloc1_Phydst), 0});
        mtail = (mtail + 1) % DEPTH;
      end
      if (!st && Alloc2_en) begin
        q.push_back('{mtail, kept(Alloc2_RegW, Alloc2_Rdst, Alloc2_Rdst), kept(Alloc2_RegW, Alloc2_Rdst, Alloc2_Phydst), 0});
        mtail = (mtail + 1) % DEPTH;
      end
    end
    @(negedge Clk);
  endtask

  task automatic do_reset();
    idle();
    Rst_n = 0;
    #1;
    q.delete();
    mtail = 0;
    chk("rst_count", Count, 0);
    chk("rst_stall", ROB_Stall, 0);
    chk("rst_c1", Commit1_Commit, 0);
    chk("rst_c2", Commit2_Commit, 0);
    @(negedge Clk);
    Rst_n = 1;
  endtask

  initial begin
    @(negedge Clk);
    do_reset();
    // two allocations, out-of-order writebacks, then a dual commit
    drive(1, 1, 3, 33, 1, 1, 4, 34); step();
    chk("plan_count2", Count, 2);
    idle(); wb(1, 1, 0, 0); step();
    idle(); wb(1, 0, 0, 0); step();
    idle(); #1;
    chk("plan_dual_c1", {Commit1_Commit, Commit1_Rdst, Commit1_Phydst}, {1'b1, 5'd3, 6'd33});
    chk("plan_dual_c2", {Commit2_Commit, Commit2_Rdst, Commit2_Phydst}, {1'b1, 5'd4, 6'd34});
    step();
    chk("plan_empty", Count, 0);
    // fill to the boundary
    do_reset();
    for (int i = 0; i < 15; i++) begin
      drive(1, 1, i + 1, i + 20, 0, 0, 0, 0); step();
    end
    chk("fill15", Count, 15);
    drive(1, 1, 9, 9, 1, 1, 10, 10); step();
    chk("full_req2_stall", Count, 15);
    drive(1, 1, 17, 50, 0, 0, 0, 0); #1;
    chk("tag15", Alloc_Tag1, 15);
    step();
    chk("full16", Count, 16);
    drive(0, 0, 0, 0, 1, 1, 5, 5); step();
    idle();
    for (int i = 0; i < 16; i += 2) begin
      wb(1, i, 1, i + 1); step();
    end
    idle();
    for (int i = 0; i < 10; i++) step();
    chk("drained", Count, 0);
    // slot-2-only packing and RegW=0 zeroing
    do_reset();
    drive(1, 0, 7, 40, 0, 0, 0, 0); step();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, i + 1, i + 1, 0, 0, 0, 0); step();
    end
    drive(0, 0, 0, 0, 1, 1, 9, 50); #1;
    chk("alloc2_only_tag", Alloc_Tag2, 5);
    step();
    idle(); wb(1, 0, 0, 0); step();
    idle(); #1;
    chk("regw0_commit", {Commit1_Commit, Commit1_Rdst, Commit1_Phydst}, {1'b1, 5'd0, 6'd0});
    step();
    // flush with a non-zero head
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, i + 1, i + 1, 1, 1, i + 11, i + 11); step();
    end
    idle(); wb(1, 0, 1, 1); step();
    idle(); step();
    drive(1, 1, 20, 20, 1, 1, 21, 21); step();
    chk("pre_flush6", Count, 6);
    idle(); wb(1, 2, 0, 0); step();
    idle(); Flush = 1; wb(1, 3, 0, 0); #1;
    chk("flush_no_commit", Commit1_Commit, 0);
    step();
    idle(); step();
    chk("flush_count", Count, 0);
    drive(1, 1, 6, 6, 0, 0, 0, 0); #1;
    chk("flush_tag_head", Alloc_Tag1, 2);
    step();
    // asynchronous reset mid-burst
    do_reset();
    for (int i = 0; i < 4; i++) begin
      drive(1, 1, i + 1, i + 1, 1, 1, i + 2, i + 2); step();
    end
    drive(1, 1, 30, 30, 0, 0, 0, 0); wb(1, 0, 0, 0); step();
    chk("burst9", Count, 9);
    drive(1, 1, 1, 1, 1, 1, 2, 2); #2;
    Rst_n = 0; #1;
    q.delete(); mtail = 0;
    chk("async_count", Count, 0);
    chk("async_c1", Commit1_Commit, 0);
    @(negedge Clk);
    Rst_n = 1; idle(); wb(1, 3, 1, 0); step();
    idle(); step();
    chk("stale_wb", Commit1_Commit, 0);
    // random traffic
    do_reset();
    for (int n = 0; n < 800; n++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 63),
            $urandom_range(0, 1), $urandom_range(0, 3) != 0, $urandom_range(0, 31), $urandom_range(0, 63));
      WB1_en = $urandom_range(0, 2) != 0;
      WB2_en = $urandom_range(0, 2) != 0;
      WB1_Tag = (q.size() > 0 && $urandom_range(0, 4) != 0) ? TAG_W'(q[$urandom_range(0, q.size() - 1)].tag) : TAG_W'($urandom);
      WB2_Tag = (q.size() > 0 && $urandom_range(0, 4) != 0) ? TAG_W'(q[$urandom_range(0, q.size() - 1)].tag) : TAG_W'($urandom);
      Flush = $urandom_range(0, 39) == 0;
      step();
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
